clock_monitor_100khz: RTL

Companion to the 1 MHz to 100 kHz divider. Runs on the 1 MHz clock and consumes the divided clock. Produces one-cycle rise/fall enable strobes for downstream logic in the 1 MHz domain. Measures every half-period of the divided clock and reports lock, a sticky fault, and the last measured half-period, so avionics logic can detect a stuck or mis-rated slow clock.

---
 rtl/clock_monitor_100khz.sv | 151 +++++++++++++++
 1 files changed

// File: rtl/clock_monitor_100khz.sv
// Clock monitor for the divided 100 kHz clock, running in the 1 MHz domain.
// Emits edge strobes, measures half-periods, and reports lock and sticky fault.
module clock_monitor_100khz #(
    parameter int NOMINAL_HALF = 5,
    parameter int TOL          = 1,
    parameter int LOCK_COUNT   = 4,
    parameter int CNT_W        = 8
) (
    input  logic             CLK_1MHZ_IN,
    input  logic             RESET,
    input  logic             CLK_100KHZ_IN,
    input  logic             FAULT_CLR,
    output logic             RISE_STROBE,
    output logic             FALL_STROBE,
    output logic             LOCKED,
    output logic             FAULT,
    output logic [CNT_W-1:0] HALF_PERIOD_OUT
);

    localparam int GW = $clog2(LOCK_COUNT + 1);

    localparam logic [CNT_W-1:0] LO_LIM  = CNT_W'(NOMINAL_HALF - TOL);
    localparam logic [CNT_W-1:0] HI_LIM  = CNT_W'(NOMINAL_HALF + TOL);
    localparam logic [CNT_W-1:0] TMO_LIM = CNT_W'(NOMINAL_HALF + TOL + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    localparam logic [GW-1:0]    LOCK_N  = GW'(LOCK_COUNT);

    typedef enum logic [1:0] {
        S_ACQUIRE,
        S_CHECK,
        S_LOCKED,
        S_FAULT
    } state_t;

    state_t           state;
    state_t           state_n;
    logic             sync1;
    logic             sync2;
    logic             prev;
    logic [CNT_W-1:0] cnt;
    logic [GW-1:0]    good_cnt;
    logic [GW-1:0]    good_n;
    logic [GW-1:0]    good_inc;
    logic             edge_seen;
    logic             is_good;
    logic             timeout;
    logic             bad_evt;

    assign edge_seen = sync2 ^ prev;
    assign is_good   = edge_seen && (cnt >= LO_LIM) && (cnt <= HI_LIM);
    assign timeout   = !edge_seen && (cnt == TMO_LIM);
    assign bad_evt   = (edge_seen && !is_good) || timeout;
    assign good_inc  = good_cnt + GW'(1);

    // Bring the monitored clock into this domain and keep a delayed copy.
    always_ff @(posedge CLK_1MHZ_IN or posedge RESET) begin
        if (RESET) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
            prev  <= 1'b0;
        end else begin
            sync1 <= CLK_100KHZ_IN;
            sync2 <= sync1;
            prev  <= sync2;
        end
    end

    // Registered edge strobes, independent of the lock state.
    always_ff @(posedge CLK_1MHZ_IN or posedge RESET) begin
        if (RESET) begin
            RISE_STROBE <= 1'b0;
            FALL_STROBE <= 1'b0;
        end else begin
            RISE_STROBE <= sync2 & ~prev;
            FALL_STROBE <= ~sync2 & prev;
        end
    end

    // Half-period counter: restart on each edge, saturate during a gap.
    always_ff @(posedge CLK_1MHZ_IN or posedge RESET) begin
        if (RESET) begin
            cnt <= '0;
        end else if (edge_seen) begin
            cnt <= CNT_W'(1);
        end else if (cnt != CNT_MAX) begin
            cnt <= cnt + CNT_W'(1);
        end
    end

    // Publish the measurement; the aligning edge has nothing to report.
    always_ff @(posedge CLK_1MHZ_IN or posedge RESET) begin
        if (RESET) begin
            HALF_PERIOD_OUT <= '0;
        end else if (edge_seen && state != S_ACQUIRE) begin
            HALF_PERIOD_OUT <= cnt;
        end
    end

    // Next-state logic; a clear request overrides any coincident event.
    always_comb begin
        state_n = state;
        good_n  = good_cnt;
        if (FAULT_CLR) begin
            state_n = S_ACQUIRE;
            good_n  = '0;
        end else begin
            unique case (state)
                S_ACQUIRE: begin
                    if (edge_seen) begin
                        state_n = S_CHECK;
                        good_n  = '0;
                    end
                end
                S_CHECK: begin
                    if (bad_evt) begin
                        good_n = '0;
                    end else if (is_good) begin
                        good_n = good_inc;
                        if (good_inc == LOCK_N) begin
                            state_n = S_LOCKED;
                        end
                    end
                end
                S_LOCKED: begin
                    if (bad_evt) begin
                        state_n = S_FAULT;
                    end
                end
                S_FAULT: begin
                    state_n = S_FAULT;
                end
            endcase
        end
    end

    // State, qualification count and status flags move together.
    always_ff @(posedge CLK_1MHZ_IN or posedge RESET) begin
        if (RESET) begin
            state    <= S_ACQUIRE;
            good_cnt <= '0;
            LOCKED   <= 1'b0;
            FAULT    <= 1'b0;
        end else begin
            state    <= state_n;
            good_cnt <= good_n;
            LOCKED   <= (state_n == S_LOCKED);
            FAULT    <= (state_n == S_FAULT);
        end
    end

endmodule
